// File: rtl/cpu_boot_pkg.sv
// rtl/cpu_boot_pkg.sv - shared state encoding and counter sizing for the boot loader
package cpu_boot_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HOLD   = 3'd1,
        LOAD   = 3'd2,
        SETTLE = 3'd3,
        RUN    = 3'd4,
        FAULT  = 3'd5
    } boot_state_t;

    // Width needed to hold the value HOLD_CYCLES; never narrower than one bit.
    function automatic int hold_cnt_width(input int hold_cycles);
        return (hold_cycles < 1) ? 1 : $clog2(hold_cycles + 1);
    endfunction

endpackage

// File: rtl/cpu_boot_loader_hold_counter.sv
// rtl/cpu_boot_loader_hold_counter.sv - loadable down-counter with zero flag for HOLD/SETTLE timing
module boot_hold_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Reload has priority; otherwise count down and rest at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cpu_boot_loader.sv
// rtl/cpu_boot_loader.sv - holds CPU in reset, streams image into memory, releases CPU; optional BOOT_CHECKSUM_EN
module cpu_boot_loader
    import cpu_boot_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int HOLD_CYCLES = 4,
    parameter int BASE_ADDR   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  boot_req,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int                    CW          = hold_cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0]         HOLD_RELOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;

    boot_state_t           state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  handshake;
    logic                  at_last_addr;
    logic                  cnt_run;
    logic                  cnt_zero;

    assign handshake    = in_valid & in_ready;
    assign at_last_addr = (addr_q == LAST_ADDR);

    // The counter only runs while timing HOLD or SETTLE; in every other state
    // it sits preloaded so both timed states start from a full count.
    assign cnt_run = (state == HOLD) || (state == SETTLE);

    boot_hold_counter #(
        .WIDTH(CW)
    ) u_hold_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (!cnt_run),
        .en      (cnt_run),
        .load_val(HOLD_RELOAD),
        .zero    (cnt_zero)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;
    logic                  sum_ok;

    assign sum_ok = (sum_q == in_data);

    // Running sum of every word actually written to memory, cleared per boot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
        end else if (boot_req && ((state == IDLE) || (state == RUN) || (state == FAULT))) begin
            sum_q <= '0;
        end else if ((state == LOAD) && handshake && !in_last) begin
            sum_q <= sum_q + in_data;
        end
    end
`endif

    // Boot sequencer: all outputs are registered and change on state transitions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr_q    <= BASE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, RUN, FAULT: begin
                    if (boot_req) begin
                        state    <= HOLD;
                        addr_q   <= BASE;
                        in_ready <= 1'b0;
                        cpu_rst  <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (handshake) begin
`ifdef BOOT_CHECKSUM_EN
                        if (in_last) begin
                            // Final word is the checksum; it is compared, never written.
                            in_ready <= 1'b0;
                            if (sum_ok) begin
                                state <= SETTLE;
                            end else begin
                                state <= FAULT;
                                err   <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= addr_q;
                            mem_wdata <= in_data;
                            if (at_last_addr) begin
                                state    <= FAULT;
                                in_ready <= 1'b0;
                                err      <= 1'b1;
                                busy     <= 1'b0;
                            end else begin
                                addr_q <= addr_q + 1'b1;
                            end
                        end
`else
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= in_data;
                        if (in_last) begin
                            state    <= SETTLE;
                            in_ready <= 1'b0;
                        end else if (at_last_addr) begin
                            // Memory full and more data promised: stop without wrapping.
                            state    <= FAULT;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
`endif
                    end
                end
                SETTLE: begin
                    if (cnt_zero) begin
                        state   <= RUN;
                        cpu_rst <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// tb/tb_cpu_boot_loader.sv - scoreboard bench for cpu_boot_loader
module tb_cpu_boot_loader;

`ifdef BOOT_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        boot_req;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        mem_we;
    logic [1:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        sb[$];
    logic [1:0] exp_addr;
    logic [1:0] last_exp_addr;

    cpu_boot_loader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (2),
        .HOLD_CYCLES(4),
        .BASE_ADDR  (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .boot_req (boot_req),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge and retire any memory write against the scoreboard.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (mem_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = sb.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write_content: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end else if (sb.size() != 0) begin
            checks++;
            errors++;
            e = sb.pop_front();
            $display("FAIL write_latency: mem_we=%b one cycle after handshake, expected 1 (addr=%0h data=%0h)",
                     mem_we, e.addr, e.data);
        end
    endtask

    // Present one beat; if it will handshake, queue the write it should cause.
    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        logic hs;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        hs = v && (in_ready === 1'b1);
        if (hs && !(CHK && l)) begin
            sb.push_back({exp_addr, d});
            last_exp_addr = exp_addr;
            if (exp_addr != 2'd3) exp_addr = exp_addr + 2'd1;
        end
        tick();
    endtask

    task automatic do_boot();
        boot_req = 1'b1;
        exp_addr = 2'd0;
        tick();
        boot_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({cpu_rst, in_ready, busy, done, err, mem_we} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got cpu_rst,in_ready,busy,done,err,mem_we=%b, expected 100000",
                     {cpu_rst, in_ready, busy, done, err, mem_we});
        end
        checks++;
        if (mem_addr !== 2'd0 || mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_mem_port: got addr=%0h data=%0h, expected 0 0", mem_addr, mem_wdata);
        end
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        checks++;
        if ({cpu_rst, in_ready, busy, done} !== 4'b1000) begin
            errors++;
            $display("FAIL idle_after_reset: got cpu_rst,in_ready,busy,done=%b, expected 1000",
                     {cpu_rst, in_ready, busy, done});
        end
    endtask

    task automatic test_boot_image();
        do_boot();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({cpu_rst, in_ready, busy} !== 3'b101) begin
                errors++;
                $display("FAIL hold_cycle%0d: got cpu_rst,in_ready,busy=%b, expected 101", i,
                         {cpu_rst, in_ready, busy});
            end
            tick();
        end
        checks++;
        if ({cpu_rst, in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL load_entry: got cpu_rst,in_ready=%b, expected 11", {cpu_rst, in_ready});
        end
        drive(1'b1, 32'h11, 1'b0);
        drive(1'b1, 32'h22, 1'b0);
        drive(1'b1, 32'h33, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({cpu_rst, in_ready, done} !== 3'b100) begin
                errors++;
                $display("FAIL settle_cycle%0d: got cpu_rst,in_ready,done=%b, expected 100", i,
                         {cpu_rst, in_ready, done});
            end
            tick();
        end
        checks++;
        if ({cpu_rst, busy, done, err} !== 4'b0010) begin
            errors++;
            $display("FAIL run_entry: got cpu_rst,busy,done,err=%b, expected 0010", {cpu_rst, busy, done, err});
        end
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reboot();
        do_boot();
        checks++;
        if ({cpu_rst, done, busy} !== 3'b101) begin
            errors++;
            $display("FAIL reboot_entry: got cpu_rst,done,busy=%b, expected 101", {cpu_rst, done, busy});
        end
        repeat (4) tick();
        if (CHK) drive(1'b1, 32'hAB, 1'b0);
        drive(1'b1, 32'hAB, 1'b1);
        in_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if ({cpu_rst, done} !== 2'b01 || sb.size() != 0) begin
            errors++;
            $display("FAIL reboot_run: got cpu_rst,done=%b pending=%0d, expected 01 pending=0",
                     {cpu_rst, done}, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  vpat;
        logic [31:0] dat[5];
        vpat = 5'b11001;
        dat  = '{32'h1, 32'h0, 32'h0, 32'h2, 32'h3};
        do_boot();
        repeat (4) tick();
        for (int i = 0; i < 5; i++) drive(vpat[i], dat[i], i == 4);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (mem_addr !== last_exp_addr) begin
            errors++;
            $display("FAIL gaps_last_addr: got %0h, expected %0h", mem_addr, last_exp_addr);
        end
        repeat (4) tick();
        checks++;
        if ({cpu_rst, done, err} !== 3'b010) begin
            errors++;
            $display("FAIL gaps_run: got cpu_rst,done,err=%b, expected 010", {cpu_rst, done, err});
        end
    endtask

    task automatic test_overflow();
        do_boot();
        repeat (4) tick();
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h51 + i, 1'b0);
        checks++;
        if ({err, cpu_rst, in_ready, busy, done} !== 5'b11000) begin
            errors++;
            $display("FAIL overflow_fault: got err,cpu_rst,in_ready,busy,done=%b, expected 11000",
                     {err, cpu_rst, in_ready, busy, done});
        end
        drive(1'b1, 32'h55, 1'b0);
        in_valid = 1'b0;
        tick();
        checks++;
        if ({err, cpu_rst, in_ready} !== 3'b110 || sb.size() != 0) begin
            errors++;
            $display("FAIL overflow_sticky: got err,cpu_rst,in_ready=%b pending=%0d, expected 110 pending=0",
                     {err, cpu_rst, in_ready}, sb.size());
        end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        do_boot();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL chk_err_clear: got err=%b, expected 0", err);
        end
        repeat (4) tick();
        drive(1'b1, 32'h1, 1'b0);
        drive(1'b1, 32'h2, 1'b0);
        drive(1'b1, 32'h3, 1'b1);
        in_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if ({cpu_rst, done, err} !== 3'b010) begin
            errors++;
            $display("FAIL chk_match: got cpu_rst,done,err=%b, expected 010", {cpu_rst, done, err});
        end
        do_boot();
        repeat (4) tick();
        drive(1'b1, 32'h1, 1'b0);
        drive(1'b1, 32'h2, 1'b0);
        drive(1'b1, 32'h4, 1'b1);
        in_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if ({err, cpu_rst, done, in_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL chk_mismatch: got err,cpu_rst,done,in_ready=%b, expected 1100",
                     {err, cpu_rst, done, in_ready});
        end
    endtask
`endif

    task automatic test_reset_mid_load();
        do_boot();
        repeat (4) tick();
        drive(1'b1, 32'h61, 1'b0);
        drive(1'b1, 32'h62, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({cpu_rst, mem_we, in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL async_abort: got cpu_rst,mem_we,in_ready=%b, expected 100", {cpu_rst, mem_we, in_ready});
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({cpu_rst, in_ready, busy, done, err} !== 5'b10000 || mem_addr !== 2'd0) begin
            errors++;
            $display("FAIL idle_after_abort: got flags=%b addr=%0h, expected 10000 addr=0",
                     {cpu_rst, in_ready, busy, done, err}, mem_addr);
        end
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
    endtask

    initial begin
        boot_req      = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        in_last       = 1'b0;
        exp_addr      = 2'd0;
        last_exp_addr = 2'd0;
        test_reset();
        test_boot_image();
        test_reboot();
        test_back_to_back();
        test_overflow();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_load();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending writes, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_boot_loader.md
Name: cpu_boot_loader

Overview:
- Synthesizable successor to the bench-level reset/preload sequence. It holds the CPU in reset, streams a program image into instruction/data memory over a valid/ready port, then releases the CPU.
- Parametrised in data width, memory depth and reset-hold length. Adds overflow detection and re-boot on request, which the bench sequence lacks.
- Sits between the host/loader link and the five-cycle CPU plus its memory write port.

Parameters:
- DATA_WIDTH, 32, memory word width.
- ADDR_WIDTH, 10, word-address width; capacity is 2**ADDR_WIDTH words.
- HOLD_CYCLES, 4, cycles cpu_rst stays asserted before load and after load; must be >= 1.
- BASE_ADDR, 0, first word address written.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- boot_req  in  1  one-cycle pulse; starts a boot sequence.
- in_valid  in  1  image word valid.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  DATA_WIDTH  image word.
- in_last  in  1  marks the final word of the image.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- cpu_rst  out  1  active-high reset to the CPU.
- busy  out  1  sequence in progress.
- done  out  1  image loaded and CPU running.
- err  out  1  sticky image overflow (or checksum) error.

Behaviour:
- Reset (rst=0, async): state IDLE. cpu_rst=1, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err=0, counters=0.
- States: IDLE, HOLD, LOAD, SETTLE, RUN, FAULT.
- IDLE:
  - cpu_rst=1.
  - boot_req -> HOLD; hold counter cleared, err cleared, address reset to BASE_ADDR.
- HOLD:
  - cpu_rst=1, busy=1.
  - Counts HOLD_CYCLES cycles, then -> LOAD.
- LOAD:
  - in_ready=1 registered. A handshake is in_valid & in_ready.
  - Each handshake produces, on the next clock edge, mem_we=1 for exactly one cycle with mem_addr=current address and mem_wdata=in_data. The address then increments.
  - Write latency is 1 cycle from handshake to write.
  - Handshake with in_last=1 -> SETTLE; in_ready drops the following cycle.
  - Overflow: a handshake at address 2**ADDR_WIDTH-1 with in_last=0 writes the word, sets err, and goes -> FAULT. The address never wraps.
- SETTLE:
  - cpu_rst=1 for HOLD_CYCLES cycles, so the final write has landed before release. Then -> RUN.
- RUN:
  - cpu_rst=0, done=1, busy=0.
  - boot_req -> HOLD: re-boot, done=0, cpu_rst=1 on the next cycle.
- FAULT:
  - cpu_rst=1, err=1, busy=0, in_ready=0.
  - boot_req -> HOLD, clearing err.
- boot_req in HOLD, LOAD or SETTLE is ignored.
- in_valid outside LOAD is ignored; no write occurs.
- Reset asserted mid-LOAD aborts immediately: mem_we=0 and cpu_rst=1 asynchronously. A partial image is not rewritten on deassertion.
- Single-word image (in_last on the first word): one write to BASE_ADDR, then SETTLE.
- Counters are sized with $clog2(HOLD_CYCLES+1).

Optional Feature:
- Macro BOOT_CHECKSUM_EN.
- Defined:
  - The word carrying in_last is a checksum, not a memory word, and is not written.
  - A running sum of all written words, modulo 2**DATA_WIDTH, is compared to it. Match -> SETTLE; mismatch -> FAULT with err=1.
- Undefined: the in_last word is ordinary data and is written. No accumulator is present.

Decomposition:
- Package cpu_boot_pkg holds the boot_state_t enum (IDLE, HOLD, LOAD, SETTLE, RUN, FAULT) and the HOLD counter width helper.
- One sub-module, boot_hold_counter: a loadable down-counter with a zero flag, used by both HOLD and SETTLE.

Test Plan:
- Reset, then boot_req with HOLD_CYCLES=4 and a 3-word image 0x11,0x22,0x33 (last on 0x33):
  - cpu_rst stays 1 through 4 hold cycles, the load, and 4 settle cycles.
  - Writes mem[0..2]=0x11,0x22,0x33, each 1 cycle after its handshake.
  - Then done=1 and cpu_rst=0.
- Backpressure-free gaps: in_valid toggles 1,0,0,1,1 -> exactly 3 writes at consecutive addresses, no duplicates.
- Overflow with ADDR_WIDTH=2 and 5 words, no in_last:
  - Writes mem[0..3].
  - err=1 on the cycle after the 4th handshake, FAULT, cpu_rst=1, in_ready=0.
  - The 5th word is not accepted.
- boot_req while in RUN -> cpu_rst rises next cycle and done=0. A new 1-word image 0xAB writes mem[0] and returns to RUN.
- rst pulled low mid-LOAD after 2 words -> cpu_rst=1 and mem_we=0 immediately. After release the state is IDLE with mem_addr=0.
- With BOOT_CHECKSUM_EN: words 0x1,0x2 plus checksum 0x3 -> RUN with 2 writes. Checksum 0x4 -> FAULT, err=1, cpu_rst=1.
